// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns PC generation, issues single-outstanding fetch requests
// and hands each accepted (or misaligned) PC to IF, tagging redirected entries.
module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] EXCP_PC  = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  input  logic        go_excp_entry,
  input  logic        eret_flush,
  input  logic [31:0] cp0_epc,
  output logic        pfs_to_fs_valid,
  output logic [33:0] pfs_to_fs_bus,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_cancel_q, hold_cancel_d;
  logic        hold_adel_q, hold_adel_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_pc_q, rd_pc_d;
  logic        rd_flush_q, rd_flush_d;
  logic        req_live_q, req_live_d;

  logic        flush_in_s;
  logic        redir_in_s;
  logic [31:0] redir_tgt_s;
  logic        take_new_s;
  logic        rd_any_s;
  logic [31:0] rd_tgt_s;
  logic        misal_s;
  logic        req_s;

  // Redirect selection; a late branch never displaces a pending flush.
  always_comb begin
    flush_in_s = go_excp_entry | eret_flush;
    redir_in_s = flush_in_s | br_taken;
    if (go_excp_entry) begin
      redir_tgt_s = EXCP_PC;
    end else if (eret_flush) begin
      redir_tgt_s = cp0_epc;
    end else begin
      redir_tgt_s = br_target;
    end
    take_new_s = redir_in_s & ~(~flush_in_s & rd_valid_q & rd_flush_q);
    rd_any_s   = rd_valid_q | redir_in_s;
    rd_tgt_s   = take_new_s ? redir_tgt_s : rd_pc_q;
    misal_s    = (pc_q[1:0] != 2'b00);
    // An outstanding request is held stable regardless of new events.
    req_s      = (state_q == S_REQ) &
                 (req_live_q | (~br_stall & ~misal_s & ~rd_valid_q & ~redir_in_s));
  end

  // Next-state logic for PC, held entry and pending redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_pc_d     = hold_pc_q;
    hold_cancel_d = hold_cancel_q;
    hold_adel_d   = hold_adel_q;
    rd_valid_d    = rd_valid_q;
    rd_pc_d       = rd_pc_q;
    rd_flush_d    = rd_flush_q;
    req_live_d    = req_live_q;

    if (take_new_s) begin
      rd_valid_d = 1'b1;
      rd_pc_d    = redir_tgt_s;
      rd_flush_d = flush_in_s;
    end else begin
      rd_valid_d = rd_valid_q;
    end

    case (state_q)
      S_REQ: begin
        if (req_s) begin
          if (inst_addr_ok) begin
            hold_pc_d     = pc_q;
            hold_adel_d   = 1'b0;
            hold_cancel_d = rd_any_s;
            pc_d          = pc_q + 32'd4;
            req_live_d    = 1'b0;
            state_d       = S_HOLD;
          end else begin
            req_live_d = 1'b1;
          end
        end else if (rd_any_s) begin
          pc_d       = rd_tgt_s;
          rd_valid_d = 1'b0;
          rd_flush_d = 1'b0;
        end else if (misal_s) begin
          hold_pc_d     = pc_q;
          hold_adel_d   = 1'b1;
          hold_cancel_d = 1'b0;
          state_d       = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redir_in_s) begin
          hold_cancel_d = 1'b1;
        end else begin
          hold_cancel_d = hold_cancel_q;
        end
        if (fs_allowin) begin
          if (rd_any_s) begin
            pc_d       = rd_tgt_s;
            rd_valid_d = 1'b0;
            rd_flush_d = 1'b0;
          end else begin
            pc_d = pc_q;
          end
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d    = S_REQ;
        req_live_d = 1'b0;
      end
    endcase
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      hold_pc_q     <= 32'h0000_0000;
      hold_cancel_q <= 1'b0;
      hold_adel_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_pc_q       <= 32'h0000_0000;
      rd_flush_q    <= 1'b0;
      req_live_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_pc_q     <= hold_pc_d;
      hold_cancel_q <= hold_cancel_d;
      hold_adel_q   <= hold_adel_d;
      rd_valid_q    <= rd_valid_d;
      rd_pc_q       <= rd_pc_d;
      rd_flush_q    <= rd_flush_d;
      req_live_q    <= req_live_d;
    end
  end

  assign inst_req        = req_s & ~reset;
  assign inst_addr       = pc_q;
  assign inst_wr         = 1'b0;
  assign inst_size       = 2'b10;
  assign inst_wdata      = 32'h0000_0000;
  assign pfs_to_fs_valid = (state_q == S_HOLD) & ~reset;
  assign pfs_to_fs_bus   = {hold_cancel_q, hold_adel_q, hold_pc_q};

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-IF stage of the 5-stage MIPS pipeline, directly upstream of if_stage.
- Owns PC generation: sequential PC, branch target, exception entry and ERET return.
- Issues fetch requests on an SRAM-like instruction port (req/addr_ok) and passes each accepted PC to IF with a valid/allowin handshake.
- Buffers redirects that arrive while a request is in flight or held, and tags entries the pipeline must discard.

Parameters:
- RESET_PC, 32'hbfc00000, address of the first fetch after reset.
- EXCP_PC, 32'hbfc00380, exception entry address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fs_allowin  in  1  IF can accept an entry this cycle.
- br_taken  in  1  ID resolved a taken branch this cycle.
- br_target  in  32  branch target; valid with br_taken.
- br_stall  in  1  ID holds a branch whose target is not yet resolvable; no new request may issue.
- go_excp_entry  in  1  one-cycle exception flush from WB.
- eret_flush  in  1  one-cycle ERET flush from WB.
- cp0_epc  in  32  EPC; valid with eret_flush.
- pfs_to_fs_valid  out  1  entry offered to IF.
- pfs_to_fs_bus  out  34  {cancel[33], adel[32], pc[31:0]}.
- inst_req  out  1  fetch request.
- inst_wr  out  1  tied 0.
- inst_size  out  2  tied 2'b10.
- inst_addr  out  32  request address.
- inst_wdata  out  32  tied 0.
- inst_addr_ok  in  1  address accepted in this cycle when inst_req=1.

Behaviour:
- Registers:
  - pc: next address to fetch; reset value RESET_PC.
  - state: REQ or HOLD; reset value REQ.
  - hold_pc, hold_cancel, hold_adel: the held entry.
  - rd_valid, rd_pc: pending redirect; reset rd_valid=0.
- Reset outputs: inst_req=0, pfs_to_fs_valid=0. Reset overrides every other event in the same cycle.
- Redirect source:
  - Priority go_excp_entry > eret_flush > br_taken.
  - Target is EXCP_PC, cp0_epc or br_target respectively.
  - A new redirect overwrites rd_pc. A flush always overwrites a pending branch redirect.
- REQ state:
  - inst_req = !br_stall && pc[1:0]==0 && !rd_valid && no redirect input this cycle; inst_addr = pc.
  - Once inst_req is high, inst_req and inst_addr stay stable until inst_addr_ok, even if a redirect arrives. The redirect goes to rd_pc.
  - On the inst_addr_ok handshake:
    - hold_pc = pc, hold_adel = 0, pc <= pc+4 (32-bit wrap, no carry-out).
    - hold_cancel = 1 if a redirect is pending or arrives in the same cycle, else 0.
    - Go to HOLD.
  - If pc[1:0]!=0: no request. hold_pc = pc, hold_adel = 1, hold_cancel = 0; go to HOLD without memory access.
  - If no request is outstanding and a redirect is pending or arriving:
    - Load pc from the redirect (live input takes priority over rd_pc), clear rd_valid, stay in REQ.
    - The request for the new pc starts the next cycle.
- HOLD state:
  - pfs_to_fs_valid = 1; bus = {hold_cancel, hold_adel, hold_pc}.
  - A redirect arriving in HOLD sets hold_cancel = 1 and is recorded in rd_valid/rd_pc.
  - When fs_allowin = 1: the entry transfers.
    - If rd_valid or a redirect is arriving, pc <= redirect target and rd_valid is cleared.
    - Go to REQ.
    - Back-to-back issue resumes the following cycle; a single outstanding request is the maximum.
- IF duties:
  - IF drops the instruction data for a cancel=1 entry.
  - IF must not wait for data for an adel=1 entry; it raises AdEL (excode 5'h04, BadVAddr = pc) unless the entry is cancelled.
- Same-cycle redirect and branch:
  - A redirect in the same cycle as inst_addr_ok cancels that fetch.
  - br_taken with br_stall=1 is treated as taken; br_stall only blocks new requests.
- Single-request rule: the block never holds more than one entry and never issues while in HOLD.

Test Plan:
- Reset release, inst_addr_ok tied 1, fs_allowin=1 -> inst_addr sequence bfc00000, bfc00004, bfc00008; each pc is offered to IF with cancel=0.
- inst_addr_ok held 0 for 3 cycles at pc=bfc00010, with br_taken pulsing target=bfc00100 in cycle 1 -> inst_addr stays bfc00010 until accepted. That entry goes to IF with cancel=1; the next request is bfc00100.
- fs_allowin=0 for 4 cycles in HOLD -> pfs_to_fs_valid stays 1, bus stable, inst_req=0; fetch resumes at pc+4 the cycle after transfer.
- go_excp_entry and br_taken (target 00400020) in the same cycle -> next request is bfc00380; branch target is discarded.
- eret_flush with cp0_epc=00400002 -> no inst_req; entry {cancel=0, adel=1, pc=00400002} offered; a later go_excp_entry redirects to bfc00380.
- br_stall=1 for 5 cycles in REQ -> inst_req=0 throughout; br_taken(target 00400040) then br_stall=0 -> first request is 00400040.
